// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing one single-port RAM: round-robin grant, lock held across address/data pairs.
// Define ARB_TIMEOUT_EN to add a watchdog that releases a stale lock or outstanding read after TIMEOUT_CYCLES.
module ram_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] a_din,
    input  logic       a_valid,
    output logic       a_ready,
    output logic [7:0] a_rsp_data,
    output logic       a_rsp_valid,
    input  logic [9:0] b_din,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] b_rsp_data,
    output logic       b_rsp_valid,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic       lock_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_LOCKED
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_word;
    logic       r_owner_b;      // owner of the lock, and the last requester served
    logic [7:0] r_a_rsp_data;
    logic [7:0] r_b_rsp_data;
    logic       r_a_rsp_valid;
    logic       r_b_rsp_valid;
    logic       r_lock_timeout;

    logic       w_grant;
    logic       w_grant_b;
    logic       w_owner_valid;
    logic       w_rd_done;
    logic       w_timeout;
    logic       w_rsp_event;
    logic [7:0] w_rsp_byte;
    logic       w_cnt_expired;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Every entry to LOCKED or WAIT_RD comes from ISSUE, so clearing there restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == ST_LOCKED || r_state == ST_WAIT_RD) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_cnt_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;

    assign w_cnt_expired        = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign w_owner_valid = r_owner_b ? b_valid : a_valid;

    // NOTE: every signal gets a default before the case; a missed branch would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_b    = r_owner_b;
        w_rd_done    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (a_valid || b_valid) begin
                    w_grant      = 1'b1;
                    w_grant_b    = (a_valid && b_valid) ? !r_owner_b : b_valid;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (r_word[9:8])
                    2'b01:   w_state_next = ST_IDLE;
                    2'b11:   w_state_next = ST_WAIT_RD;
                    default: w_state_next = ST_LOCKED;
                endcase
            end
            ST_LOCKED: begin
                if (w_owner_valid) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                if (ram_tx_valid) begin
                    w_rd_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A read that times out still completes toward the owner, with an all-ones byte.
    assign w_rsp_event = w_rd_done || (w_timeout && r_state == ST_WAIT_RD);
    assign w_rsp_byte  = w_rd_done ? ram_dout : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word         <= '0;
            r_owner_b      <= 1'b1;
            r_a_rsp_data   <= '0;
            r_b_rsp_data   <= '0;
            r_a_rsp_valid  <= 1'b0;
            r_b_rsp_valid  <= 1'b0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_a_rsp_valid  <= 1'b0;
            r_b_rsp_valid  <= 1'b0;
            r_lock_timeout <= w_timeout;
            if (w_grant) begin
                r_word    <= w_grant_b ? b_din : a_din;
                r_owner_b <= w_grant_b;
            end
            if (w_rsp_event) begin
                if (r_owner_b) begin
                    r_b_rsp_data  <= w_rsp_byte;
                    r_b_rsp_valid <= 1'b1;
                end else begin
                    r_a_rsp_data  <= w_rsp_byte;
                    r_a_rsp_valid <= 1'b1;
                end
            end
        end
    end

    assign ram_rx_valid = (r_state == ST_ISSUE);
    assign ram_din      = ram_rx_valid ? r_word : '0;
    assign a_ready      = ram_rx_valid && !r_owner_b;
    assign b_ready      = ram_rx_valid && r_owner_b;
    assign a_rsp_data   = r_a_rsp_data;
    assign b_rsp_data   = r_b_rsp_data;
    assign a_rsp_valid  = r_a_rsp_valid;
    assign b_rsp_valid  = r_b_rsp_valid;
    assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, timeout/no-timeout hold check, random run vs model.
module tb_ram_port_arbiter;

    localparam int TO = 16;

    logic       clk;
    logic       rst;
    logic [9:0] a_din;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_rsp_data;
    logic       a_rsp_valid;
    logic [9:0] b_din;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_rsp_data;
    logic       b_rsp_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       lock_timeout;

    ram_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .a_din(a_din), .a_valid(a_valid), .a_ready(a_ready),
        .a_rsp_data(a_rsp_data), .a_rsp_valid(a_rsp_valid),
        .b_din(b_din), .b_valid(b_valid), .b_ready(b_ready),
        .b_rsp_data(b_rsp_data), .b_rsp_valid(b_rsp_valid),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .lock_timeout(lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // {a_ready, b_ready, ram_rx_valid, ram_din, a_rsp_valid, b_rsp_valid, a_rsp_data, b_rsp_data, lock_timeout}
    function automatic logic [31:0] dut_out();
        return {a_ready, b_ready, ram_rx_valid, ram_din, a_rsp_valid, b_rsp_valid,
                a_rsp_data, b_rsp_data, lock_timeout};
    endfunction

    typedef struct {
        logic        rst;
        logic        av;
        logic [9:0]  ad;
        logic        bv;
        logic [9:0]  bd;
        logic        tv;
        logic [7:0]  td;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic av, input logic [9:0] ad, input logic bv,
                       input logic [9:0] bd, input logic tv, input logic [7:0] td,
                       input logic ear, input logic ebr, input logic [9:0] edin,
                       input logic eav, input logic [7:0] ead);
        vec_t v;
        v.rst = r; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.tv = tv; v.td = td;
        v.exp = {ear, ebr, ear | ebr, edin, eav, 1'b0, ead, 8'h00, 1'b0};
        tbl.push_back(v);
    endtask

    // Reference model: who holds the RAM, whether a word is being issued, whether a read is outstanding.
    int         m_hold;
    int         m_last;
    int         m_cnt;
    bit         m_issue;
    bit         m_rdwait;
    logic [9:0] m_word;
    logic [7:0] m_rd [2];
    logic [31:0] exp_out;

    function automatic bit to_hit();
`ifdef ARB_TIMEOUT_EN
        return (m_cnt == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        logic       ar, br, av_o, bv_o, lt;
        logic [9:0] d;
        logic       own_valid;
        int         pick;
        ar = 1'b0; br = 1'b0; av_o = 1'b0; bv_o = 1'b0; lt = 1'b0; d = '0; pick = -1;
        own_valid = (m_hold == 0) ? a_valid : b_valid;
        if (rst) begin
            m_hold = -1; m_last = 1; m_cnt = 0; m_issue = 1'b0; m_rdwait = 1'b0;
            m_rd[0] = '0; m_rd[1] = '0;
        end else if (m_issue) begin
            m_issue = 1'b0;
            m_cnt   = 0;
            if (m_word[9:8] == 2'b01) m_hold = -1;
            else if (m_word[9:8] == 2'b11) m_rdwait = 1'b1;
        end else if (m_rdwait) begin
            if (ram_tx_valid || to_hit()) begin
                lt = !ram_tx_valid;
                m_rd[m_hold] = ram_tx_valid ? ram_dout : 8'hFF;
                if (m_hold == 0) av_o = 1'b1; else bv_o = 1'b1;
                m_hold = -1; m_rdwait = 1'b0;
            end else begin
                m_cnt++;
            end
        end else if (m_hold < 0) begin
            if (a_valid && b_valid) pick = 1 - m_last;
            else if (a_valid) pick = 0;
            else if (b_valid) pick = 1;
        end else begin
            if (own_valid) pick = m_hold;
            else if (to_hit()) begin lt = 1'b1; m_hold = -1; end
            else m_cnt++;
        end
        if (pick >= 0) begin
            m_issue = 1'b1;
            m_word  = (pick == 0) ? a_din : b_din;
            m_hold  = pick;
            m_last  = pick;
            ar = (pick == 0); br = (pick == 1); d = m_word;
        end
        exp_out = {ar, br, ar | br, d, av_o, bv_o, m_rd[0], m_rd[1], lt};
    endtask

    initial begin
        int first_lt;
        int first_br;

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_din = '0; b_din = '0;
        ram_dout = '0; ram_tx_valid = 1'b0;

        //   rst   av    ad        bv    bd        tv    td      ear   ebr   edin      eav   ead
        add(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h012, 1'b0, 10'h000, 1'b0, 8'h00,  1'b1, 1'b0, 10'h012, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h1AB, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h1AB, 1'b0, 10'h000, 1'b0, 8'h00,  1'b1, 1'b0, 10'h1AB, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h133, 1'b0, 8'h00,  1'b0, 1'b1, 10'h133, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h111, 1'b1, 10'h122, 1'b0, 8'h00,  1'b1, 1'b0, 10'h111, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h133, 1'b1, 10'h122, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h133, 1'b1, 10'h122, 1'b0, 8'h00,  1'b0, 1'b1, 10'h122, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h133, 1'b1, 10'h144, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h133, 1'b1, 10'h144, 1'b0, 8'h00,  1'b1, 1'b0, 10'h133, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h144, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h144, 1'b0, 8'h00,  1'b0, 1'b1, 10'h144, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h77,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h205, 1'b0, 10'h000, 1'b0, 8'h00,  1'b1, 1'b0, 10'h205, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h166, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h166, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 10'h300, 1'b1, 10'h166, 1'b0, 8'h00,  1'b1, 1'b0, 10'h300, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h166, 1'b1, 8'h5C,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h166, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h166, 1'b1, 8'h5C,  1'b0, 1'b0, 10'h000, 1'b1, 8'h5C);
        add(1'b0, 1'b0, 10'h000, 1'b1, 10'h166, 1'b0, 8'h00,  1'b0, 1'b1, 10'h166, 1'b0, 8'h5C);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h5C);
        add(1'b0, 1'b1, 10'h311, 1'b0, 10'h000, 1'b0, 8'h00,  1'b1, 1'b0, 10'h311, 1'b0, 8'h5C);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h5C);
        add(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h99,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00,  1'b0, 1'b0, 10'h000, 1'b0, 8'h00);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; a_valid = tbl[i].av; a_din = tbl[i].ad;
            b_valid = tbl[i].bv; b_din = tbl[i].bd;
            ram_tx_valid = tbl[i].tv; ram_dout = tbl[i].td;
            step();
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // A takes the lock and goes silent while B waits.
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; ram_tx_valid = 1'b0;
        step();
        rst = 1'b0; a_valid = 1'b1; a_din = 10'h205;
        step();
        check("hold_issue", 32'(a_ready), 32'd1);
        a_valid = 1'b0; b_valid = 1'b1; b_din = 10'h177;
        step();
        check("hold_b_stall", 32'(b_ready), 32'd0);
        first_lt = -1;
        first_br = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (lock_timeout && first_lt < 0) first_lt = k;
            if (b_ready && first_br < 0) begin
                first_br = k;
                b_valid  = 1'b0;
            end
        end
`ifdef ARB_TIMEOUT_EN
        check("timeout_cycle", 32'(first_lt), 32'd16);
        check("timeout_b_grant", 32'(first_br), 32'd17);
`else
        check("no_timeout_pulse", 32'(first_lt), 32'hFFFF_FFFF);
        check("no_timeout_b_grant", 32'(first_br), 32'hFFFF_FFFF);
`endif

        // Randomized traffic with occasional resets against the model.
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; ram_tx_valid = 1'b0;
        model_step();
        step();
        for (int c = 0; c < 3000; c++) begin
            check("rand", dut_out(), exp_out);
            rst = ($urandom_range(0, 99) == 0);
            if (a_valid && a_ready) a_valid = 1'b0;
            if (b_valid && b_ready) b_valid = 1'b0;
            if (!a_valid && $urandom_range(0, 2) == 0) begin
                a_valid = 1'b1;
                a_din   = 10'($urandom());
            end
            if (!b_valid && $urandom_range(0, 2) == 0) begin
                b_valid = 1'b1;
                b_din   = 10'($urandom());
            end
            ram_tx_valid = ($urandom_range(0, 9) < 3);
            ram_dout     = 8'($urandom());
            model_step();
            step();
        end
        check("rand_last", dut_out(), exp_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
